// File: rtl/sample_player.sv
// Clip-playback engine: streams one of NUM_CLIPS equal-length clips from a
// synchronous sample ROM to the codec write path, one sample per handshake.
module sample_player #(
  parameter int DATA_W     = 24,
  parameter int CLIP_DEPTH = 24000,
  parameter int NUM_CLIPS  = 4,
  parameter int ADDR_W     = 17,
  parameter int ROM_LAT    = 1,
  localparam int CLIP_W    = (NUM_CLIPS > 1) ? $clog2(NUM_CLIPS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_wr_en,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  input  logic [CLIP_W-1:0] clip_sel,
  input  logic [2:0]        atten,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] wdata_left,
  output logic [DATA_W-1:0] wdata_right,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int OFF_W = (CLIP_DEPTH > 1) ? $clog2(CLIP_DEPTH) : 1;
  localparam int SET_W = $clog2(ROM_LAT + 1);
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(CLIP_DEPTH - 1);
  localparam logic [SET_W-1:0] SET_MAX  = SET_W'(ROM_LAT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  logic [1:0]        state_r,    state_s;
  logic [CLIP_W-1:0] clip_r,     clip_s;
  logic              loop_r,     loop_s;
  logic [2:0]        atten_r,    atten_s;
  logic [OFF_W-1:0]  offset_r,   offset_s;
  logic [SET_W-1:0]  settle_r,   settle_s;
  logic [ADDR_W-1:0] rom_addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r,    wdata_s;
  logic              done_r,     done_s;
  logic              busy_r;
  logic              underrun_r, underrun_s;
  logic              settled_s;
  logic signed [DATA_W-1:0] rom_q_s;
  logic signed [DATA_W-1:0] sample_s;

  assign rom_addr    = rom_addr_r;
  assign wdata_left  = wdata_r;
  assign wdata_right = wdata_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign underrun    = underrun_r;

  // Next-state decode: stop beats play, play beats a same-cycle handshake.
  always_comb begin
    state_s    = state_r;
    clip_s     = clip_r;
    loop_s     = loop_r;
    atten_s    = atten_r;
    offset_s   = offset_r;
    wdata_s    = wdata_r;
    done_s     = 1'b0;
    underrun_s = underrun_r;
    settled_s  = (settle_r == SET_MAX);
    rom_q_s    = rom_q;
    sample_s   = rom_q_s >>> atten_r;
    if (stop) begin
      state_s = IDLE;
      wdata_s = {DATA_W{1'b0}};
    end else if (play) begin
      state_s    = PLAY;
      clip_s     = clip_sel;
      loop_s     = loop;
      atten_s    = atten;
      offset_s   = {OFF_W{1'b0}};
      underrun_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wdata_s = {DATA_W{1'b0}};
        end
        PLAY: begin
          if (rd_wr_en && settled_s) begin
            wdata_s = sample_s;
            if (offset_r != LAST_OFF) begin
              offset_s = offset_r + OFF_W'(1);
            end else if (loop_r) begin
              offset_s = {OFF_W{1'b0}};
            end else begin
              state_s = TAIL;
            end
          end else if (rd_wr_en) begin
            underrun_s = 1'b1;
          end else begin
            underrun_s = underrun_r;
          end
        end
        TAIL: begin
          if (rd_wr_en) begin
            state_s = IDLE;
            wdata_s = {DATA_W{1'b0}};
            done_s  = 1'b1;
          end else begin
            done_s  = 1'b0;
          end
        end
        default: begin
          state_s = IDLE;
          wdata_s = {DATA_W{1'b0}};
        end
      endcase
    end
    // The settle counter restarts whenever the registered address moves.
    addr_s = ADDR_W'(clip_s) * ADDR_W'(CLIP_DEPTH) + ADDR_W'(offset_s);
    if (addr_s != rom_addr_r) begin
      settle_s = {SET_W{1'b0}};
    end else if (settle_r != SET_MAX) begin
      settle_s = settle_r + SET_W'(1);
    end else begin
      settle_s = settle_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      clip_r     <= {CLIP_W{1'b0}};
      loop_r     <= 1'b0;
      atten_r    <= 3'd0;
      offset_r   <= {OFF_W{1'b0}};
      settle_r   <= {SET_W{1'b0}};
      rom_addr_r <= {ADDR_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      clip_r     <= clip_s;
      loop_r     <= loop_s;
      atten_r    <= atten_s;
      offset_r   <= offset_s;
      settle_r   <= settle_s;
      rom_addr_r <= addr_s;
      wdata_r    <= wdata_s;
      done_r     <= done_s;
      busy_r     <= (state_s != IDLE);
      underrun_r <= underrun_s;
    end
  end

endmodule

// File: tb/tb_sample_player.sv
// Randomised and directed bench for sample_player with a per-cycle scoreboard
// fed by a behavioural playback model.
module tb_sample_player;

  localparam int DATA_W     = 24;
  localparam int CLIP_DEPTH = 8;
  localparam int NUM_CLIPS  = 2;
  localparam int ADDR_W     = 4;
  localparam int ROM_LAT    = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_wr_en, play, stop, loop;
  logic [0:0]        clip_sel;
  logic [2:0]        atten;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q, wdata_left, wdata_right;
  logic              busy, done, underrun;
  logic              neg_mode;

  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              underrun;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Playback model: mode 0 idle, 1 playing, 2 holding last sample.
  int   m_mode, m_clip, m_pos, m_loop, m_atten, m_addr, m_chg, m_edges;
  logic [DATA_W-1:0] m_out;
  logic m_done, m_und;

  always #5 clk = ~clk;

  sample_player #(
    .DATA_W(DATA_W), .CLIP_DEPTH(CLIP_DEPTH), .NUM_CLIPS(NUM_CLIPS),
    .ADDR_W(ADDR_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .rd_wr_en(rd_wr_en), .play(play), .stop(stop),
    .loop(loop), .clip_sel(clip_sel), .atten(atten), .rom_addr(rom_addr),
    .rom_q(rom_q), .wdata_left(wdata_left), .wdata_right(wdata_right),
    .busy(busy), .done(done), .underrun(underrun)
  );

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    if (neg_mode) return 24'hF00000;
    return DATA_W'(int'(a) * 16);
  endfunction

  always_ff @(posedge clk) rom_q <= rom_word(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one clock cycle; the model predicts what the DUT shows after the edge.
  task automatic step(input logic p, input logic s, input logic rd, input logic rs);
    exp_t e;
    bit settled;
    logic signed [DATA_W-1:0] smp;
    play = p; stop = s; rd_wr_en = rd; reset = rs;
    if (!rs) begin
      m_mode = 0; m_clip = 0; m_pos = 0; m_loop = 0; m_atten = 0; m_addr = 0;
      m_out = '0; m_done = 1'b0; m_und = 1'b0; m_chg = m_edges + 1;
    end else begin
      settled = (m_edges - m_chg) >= ROM_LAT;
      m_done = 1'b0;
      if (s) begin
        m_mode = 0; m_out = '0;
      end else if (p) begin
        m_clip = int'(clip_sel); m_loop = int'(loop); m_atten = int'(atten);
        m_pos = 0; m_mode = 1; m_und = 1'b0;
      end else if (m_mode == 1 && rd) begin
        if (settled) begin
          smp = rom_word(ADDR_W'(m_clip * CLIP_DEPTH + m_pos));
          m_out = smp >>> m_atten;
          if (m_pos == CLIP_DEPTH - 1) begin
            if (m_loop != 0) m_pos = 0;
            else m_mode = 2;
          end else begin
            m_pos++;
          end
        end else begin
          m_und = 1'b1;
        end
      end else if (m_mode == 2 && rd) begin
        m_out = '0; m_done = 1'b1; m_mode = 0;
      end
      if (m_clip * CLIP_DEPTH + m_pos != m_addr) begin
        m_addr = m_clip * CLIP_DEPTH + m_pos;
        m_chg  = m_edges + 1;
      end
    end
    e.wdata = m_out; e.busy = (m_mode != 0); e.done = m_done;
    e.underrun = m_und; e.addr = ADDR_W'(m_addr);
    @(posedge clk);
    m_edges++;
    sb_q.push_back(e);
    #1;
  endtask

  task automatic cyc(input logic p, input logic s, input logic rd);
    step(p, s, rd, 1'b1);
  endtask

  // Monitor: every cycle with a pending expectation is compared.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("wdata_left",  32'(wdata_left),  32'(e.wdata));
      check("wdata_right", 32'(wdata_right), 32'(e.wdata));
      check("busy",        32'(busy),        32'(e.busy));
      check("done",        32'(done),        32'(e.done));
      check("underrun",    32'(underrun),    32'(e.underrun));
      check("rom_addr",    32'(rom_addr),    32'(e.addr));
    end
  end

  initial begin
    reset = 1'b0; play = 1'b0; stop = 1'b0; rd_wr_en = 1'b0; loop = 1'b0;
    clip_sel = 1'b0; atten = 3'd0; neg_mode = 1'b0;
    m_mode = 0; m_clip = 0; m_pos = 0; m_loop = 0; m_atten = 0; m_addr = 0;
    m_chg = 0; m_edges = 0; m_out = '0; m_done = 1'b0; m_und = 1'b0;

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);

    // One-shot of clip 1, handshake every fourth cycle.
    clip_sel = 1'b1; loop = 1'b0; atten = 3'd0;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (9) begin
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Looping clip 0 across the wrap.
    clip_sel = 1'b0; loop = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (20) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
    end
    cyc(1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);

    // Negative sample with attenuation.
    neg_mode = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    clip_sel = 1'b0; loop = 1'b1; atten = 3'd4;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("atten_left",  32'(wdata_left),  32'h00FF0000);
    check("atten_right", 32'(wdata_right), 32'h00FF0000);
    cyc(1'b0, 1'b1, 1'b0);
    neg_mode = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // Back-to-back handshakes outrun the ROM.
    clip_sel = 1'b0; loop = 1'b0; atten = 3'd0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    check("underrun_set", 32'(underrun), 32'h1);
    cyc(1'b1, 1'b0, 1'b0);
    check("underrun_clr", 32'(underrun), 32'h0);
    cyc(1'b0, 1'b1, 1'b0);

    // Stop mid-clip, play+stop together, retrigger, play with handshake.
    clip_sel = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (2) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
    end
    clip_sel = 1'b0;
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);

    // Random traffic.
    repeat (400) begin
      clip_sel = 1'($urandom_range(0, 1));
      loop     = 1'($urandom_range(0, 1));
      atten    = 3'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 59) == 0),
          1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of playback.
    clip_sel = 1'b1; loop = 1'b1; atten = 3'd1;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (4) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_left",     32'(wdata_left),  32'h0);
    check("rst_right",    32'(wdata_right), 32'h0);
    check("rst_busy",     32'(busy),        32'h0);
    check("rst_done",     32'(done),        32'h0);
    check("rst_underrun", 32'(underrun),    32'h0);
    check("rst_addr",     32'(rom_addr),    32'h0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
